// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, single-outstanding SRAM fetch, IF/ID register
//
// Owns the PC and the IF/ID pipeline register. One SRAM request is
// outstanding at a time. SRAM data that returns while ID is stalled is
// parked in a one-entry skid buffer. Branches resolved in ID use MIPS
// delay-slot semantics: the instruction delivered after a taken branch is
// its delay slot, and the PC then moves to the branch target.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   stall             ID cannot accept; IF/ID, skid buffer and PC hold
//   jmp, dest         ID branch/jump taken and its target
//   flush, flush_pc   exception/eret redirect (highest priority)
//   inst_req          SRAM request valid (combinational)
//   inst_addr         SRAM request address = PC (combinational)
//   inst_addr_ok      SRAM accepted the request this cycle
//   inst_data_ok      SRAM read data valid this cycle
//   inst_rdata        SRAM instruction word
//   if_valid          IF/ID holds an instruction
//   if_pc, if_inst    PC and word of that instruction (word is 0 on if_adel)
//   if_in_ds          instruction is a branch delay slot
//   if_adel           fetch address was misaligned
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] dest,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_in_ds,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic        cancel;
    logic        cancel_nxt;
    logic [31:0] skid_data;

    logic        pc_misaligned;
    logic        if_free;
    logic        jmp_take;
    logic        req_deliver;
    logic        wait_deliver;
    logic        hold_deliver;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic [31:0] pc_after;
    logic        skid_load;

    assign pc_misaligned = (pc[1:0] != 2'b00);

    // IF/ID can take a new instruction if empty or being consumed by ID now.
    assign if_free  = !if_valid || !stall;

    // A branch counts only when ID actually retires it this cycle.
    assign jmp_take = jmp && !stall && if_valid;

    // A misaligned PC never reaches the SRAM; it is delivered directly as an
    // address-error instruction.
    assign req_deliver  = (state == S_REQ)  && pc_misaligned && if_free;
    assign wait_deliver = (state == S_WAIT) && inst_data_ok && !cancel && if_free;
    assign hold_deliver = (state == S_HOLD) && !stall;
    assign deliver      = !flush && (req_deliver || wait_deliver || hold_deliver);

    assign skid_load = !flush && (state == S_WAIT) && inst_data_ok && !cancel && !if_free;

    always_comb begin
        deliver_inst = 32'd0;
        if (hold_deliver) begin
            deliver_inst = skid_data;
        end else if (wait_deliver) begin
            deliver_inst = inst_rdata;
        end
    end

    // The delay slot is always the next delivery; the redirect is applied
    // when that delivery happens.
    always_comb begin
        pc_after = pc + 32'd4;
        if (jmp_take) begin
            pc_after = dest;
        end else if (pend_v) begin
            pc_after = pend_tgt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_REQ;
            cancel <= 1'b0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        if (flush) begin
            cancel_nxt = 1'b0;
            state_nxt  = S_REQ;
            unique case (state)
                S_REQ: begin
                    // The request issued this cycle is in flight; its data
                    // must be discarded before fetching from flush_pc.
                    if (inst_addr_ok && !pc_misaligned) begin
                        cancel_nxt = 1'b1;
                        state_nxt  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Data returning in the same cycle is simply dropped.
                    if (!inst_data_ok) begin
                        cancel_nxt = 1'b1;
                        state_nxt  = S_WAIT;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (pc_misaligned) begin
                        if (if_free) begin
                            state_nxt = S_ERR;
                        end
                    end else if (inst_addr_ok) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        cancel_nxt = 1'b0;
                        if (cancel || if_free) begin
                            state_nxt = S_REQ;
                        end else begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state_nxt = S_REQ;
                    end
                end
                S_ERR: state_nxt = S_ERR;
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        inst_req  = (state == S_REQ) && !pc_misaligned && !reset;
        inst_addr = pc;
    end

    // ------------------------------------------------------------------
    // PC, pending branch target, skid buffer and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            pend_v    <= 1'b0;
            pend_tgt  <= 32'd0;
            skid_data <= 32'd0;
            if_valid  <= 1'b0;
            if_pc     <= 32'd0;
            if_inst   <= 32'd0;
            if_in_ds  <= 1'b0;
            if_adel   <= 1'b0;
        end else if (flush) begin
            pc        <= flush_pc;
            pend_v    <= 1'b0;
            skid_data <= 32'd0;
            if_valid  <= 1'b0;
        end else begin
            if (skid_load) begin
                skid_data <= inst_rdata;
            end
            if (deliver) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= deliver_inst;
                if_adel  <= req_deliver;
                if_in_ds <= jmp_take || pend_v;
                pc       <= pc_after;
                pend_v   <= 1'b0;
            end else begin
                if (!stall) begin
                    if_valid <= 1'b0;
                end
                // Branch retired before its delay slot arrived: remember
                // the target until the delay slot is delivered.
                if (jmp_take) begin
                    pend_v   <= 1'b1;
                    pend_tgt <= dest;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed vector table plus reactive SRAM sequence for if_fetch
module tb_if_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jmp;
    logic [31:0] dest;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_in_ds;
    logic        if_adel;

    if_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jmp          (jmp),
        .dest         (dest),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_in_ds     (if_in_ds),
        .if_adel      (if_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        jp;
        logic [31:0] dst;
        logic        fl;
        logic [31:0] fpc;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_ds;
        logic        e_adel;
    } vec_t;

    vec_t vq[$];
    int   n_chk;
    int   n_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stl, input logic jp, input logic [31:0] dst,
                       input logic fl, input logic [31:0] fpc, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_ds, input logic e_adel);
        vec_t v;
        v.rst = rst; v.stl = stl; v.jp = jp; v.dst = dst; v.fl = fl; v.fpc = fpc;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_ds = e_ds; v.e_adel = e_adel;
        vq.push_back(v);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] out_addr;
    logic [31:0] held_addr;
    logic        outst;
    logic        acc;
    logic        held;
    int          got;

    initial begin
        n_chk = 0;
        n_miss = 0;

        // rst stl jmp dest fl flush_pc aok dok rdata | req addr vld if_pc if_inst ds adel
        // reset state, then zero-wait sequential fetch
        add(1,0,0,0,0,0,0,0,0,                       0,32'hBFC00000,0,0,0,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00000,0,0,0,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00000,            0,32'hBFC00000,0,0,0,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00004,1,32'hBFC00000,32'hBFC00000,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00004,            0,32'hBFC00004,0,32'hBFC00000,32'hBFC00000,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00008,1,32'hBFC00004,32'hBFC00004,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00008,            0,32'hBFC00008,0,32'hBFC00004,32'hBFC00004,0,0);
        // addr_ok withheld: address held stable
        add(0,0,0,0,0,0,0,0,0,                       1,32'hBFC0000C,1,32'hBFC00008,32'hBFC00008,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC0000C,0,32'hBFC00008,32'hBFC00008,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC0000C,            0,32'hBFC0000C,0,32'hBFC00008,32'hBFC00008,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00010,1,32'hBFC0000C,32'hBFC0000C,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00010,            0,32'hBFC00010,0,32'hBFC0000C,32'hBFC0000C,0,0);
        // branch at BFC00010 retired before its delay slot arrives
        add(0,0,1,32'hBFC00100,0,0,1,0,0,            1,32'hBFC00014,1,32'hBFC00010,32'hBFC00010,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00014,            0,32'hBFC00014,0,32'hBFC00010,32'hBFC00010,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00100,1,32'hBFC00014,32'hBFC00014,1,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00100,            0,32'hBFC00100,0,32'hBFC00014,32'hBFC00014,1,0);
        // stall while data returns: skid buffer / HOLD
        add(0,1,0,0,0,0,1,0,0,                       1,32'hBFC00104,1,32'hBFC00100,32'hBFC00100,0,0);
        add(0,1,0,0,0,0,0,1,32'hBFC00104,            0,32'hBFC00104,1,32'hBFC00100,32'hBFC00100,0,0);
        add(0,1,0,0,0,0,0,0,0,                       0,32'hBFC00104,1,32'hBFC00100,32'hBFC00100,0,0);
        add(0,1,0,0,0,0,0,0,0,                       0,32'hBFC00104,1,32'hBFC00100,32'hBFC00100,0,0);
        add(0,0,0,0,0,0,0,0,0,                       0,32'hBFC00104,1,32'hBFC00100,32'hBFC00100,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00108,1,32'hBFC00104,32'hBFC00104,0,0);
        // flush in WAIT, stale data two cycles later is dropped
        add(0,0,0,0,1,32'hBFC00380,0,0,0,            0,32'hBFC00108,0,32'hBFC00104,32'hBFC00104,0,0);
        add(0,0,0,0,0,0,0,0,0,                       0,32'hBFC00380,0,32'hBFC00104,32'hBFC00104,0,0);
        add(0,0,0,0,0,0,0,1,32'hDEADBEEF,            0,32'hBFC00380,0,32'hBFC00104,32'hBFC00104,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00380,0,32'hBFC00104,32'hBFC00104,0,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00380,            0,32'hBFC00380,0,32'hBFC00104,32'hBFC00104,0,0);
        // flush to a misaligned PC: address-error delivery, then ERR
        add(0,0,0,0,1,32'h00000102,0,0,0,            1,32'hBFC00384,1,32'hBFC00380,32'hBFC00380,0,0);
        add(0,0,0,0,0,0,0,0,0,                       0,32'h00000102,0,32'hBFC00380,32'hBFC00380,0,0);
        add(0,0,0,0,0,0,0,0,0,                       0,32'h00000106,1,32'h00000102,32'h00000000,0,1);
        add(0,0,0,0,0,0,0,0,0,                       0,32'h00000106,0,32'h00000102,32'h00000000,0,1);
        add(0,0,0,0,1,32'hBFC00380,0,0,0,            0,32'h00000106,0,32'h00000102,32'h00000000,0,1);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00380,0,32'h00000102,32'h00000000,0,1);
        add(0,0,0,0,0,0,0,1,32'hBFC00380,            0,32'hBFC00380,0,32'h00000102,32'h00000000,0,1);
        // delay slot delivered in the same cycle the branch retires
        add(0,1,0,0,0,0,1,0,0,                       1,32'hBFC00384,1,32'hBFC00380,32'hBFC00380,0,0);
        add(0,0,1,32'hBFC00400,0,0,0,1,32'hBFC00384, 0,32'hBFC00384,1,32'hBFC00380,32'hBFC00380,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00400,1,32'hBFC00384,32'hBFC00384,1,0);
        add(0,0,0,0,0,0,0,1,32'hBFC00400,            0,32'hBFC00400,0,32'hBFC00384,32'hBFC00384,1,0);
        // PC wrap at FFFFFFFC
        add(0,0,0,0,1,32'hFFFFFFFC,0,0,0,            1,32'hBFC00404,1,32'hBFC00400,32'hBFC00400,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hFFFFFFFC,0,32'hBFC00400,32'hBFC00400,0,0);
        add(0,0,0,0,0,0,0,1,32'h12345678,            0,32'hFFFFFFFC,0,32'hBFC00400,32'hBFC00400,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'h00000000,1,32'hFFFFFFFC,32'h12345678,0,0);
        // reset mid-transaction, late data_ok ignored in REQ
        add(1,0,0,0,0,0,0,0,0,                       0,32'h00000000,0,32'hFFFFFFFC,32'h12345678,0,0);
        add(0,0,0,0,0,0,0,1,32'hAAAAAAAA,            1,32'hBFC00000,0,0,0,0,0);
        // flush in REQ with addr_ok: in-flight data cancelled
        add(0,0,0,0,1,32'hBFC00200,1,0,0,            1,32'hBFC00000,0,0,0,0,0);
        add(0,0,0,0,0,0,0,1,32'h11111111,            0,32'hBFC00200,0,0,0,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00200,0,0,0,0,0);
        // flush coincident with data_ok in WAIT: dropped, no cancel left
        add(0,0,0,0,1,32'hBFC00300,0,1,32'h22222222, 0,32'hBFC00200,0,0,0,0,0);
        add(0,0,0,0,0,0,1,0,0,                       1,32'hBFC00300,0,0,0,0,0);
        add(0,0,0,0,0,0,0,1,32'h33333333,            0,32'hBFC00300,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,                       1,32'hBFC00304,1,32'hBFC00300,32'h33333333,0,0);

        reset = 1'b1; stall = 1'b0; jmp = 1'b0; dest = 32'd0; flush = 1'b0;
        flush_pc = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst; stall = vq[i].stl; jmp = vq[i].jp; dest = vq[i].dst;
            flush = vq[i].fl; flush_pc = vq[i].fpc; inst_addr_ok = vq[i].aok;
            inst_data_ok = vq[i].dok; inst_rdata = vq[i].rd;
            #1;
            chk($sformatf("v%0d inst_req", i),  {31'd0, inst_req}, {31'd0, vq[i].e_req});
            chk($sformatf("v%0d inst_addr", i), inst_addr, vq[i].e_addr);
            chk($sformatf("v%0d if_valid", i),  {31'd0, if_valid}, {31'd0, vq[i].e_vld});
            chk($sformatf("v%0d if_pc", i),     if_pc, vq[i].e_pc);
            chk($sformatf("v%0d if_inst", i),   if_inst, vq[i].e_inst);
            chk($sformatf("v%0d if_in_ds", i),  {31'd0, if_in_ds}, {31'd0, vq[i].e_ds});
            chk($sformatf("v%0d if_adel", i),   {31'd0, if_adel}, {31'd0, vq[i].e_adel});
        end

        // Reactive SRAM with random latency and random ID stalls: every
        // consumed instruction must be the next sequential PC, carrying
        // its own address as data (no loss, no duplication).
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; jmp = 1'b0; flush = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 32'hBFC0_0000;
        outst = 1'b0;
        out_addr = 32'd0;
        held = 1'b0;
        held_addr = 32'd0;
        got = 0;
        for (int c = 0; c < 800 && got < 24; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (held) begin
                chk("hold inst_req", {31'd0, inst_req}, 32'd1);
                chk("hold inst_addr", inst_addr, held_addr);
            end
            stall        = ($urandom_range(0, 3) == 0);
            inst_addr_ok = inst_req && ($urandom_range(0, 2) != 0);
            inst_data_ok = outst && ($urandom_range(0, 1) == 1);
            inst_rdata   = out_addr;
            #1;
            acc = inst_req && inst_addr_ok;
            held = inst_req && !inst_addr_ok;
            held_addr = inst_addr;
            if (if_valid && !stall) begin
                chk($sformatf("seq%0d if_pc", got), if_pc, exp_pc);
                chk($sformatf("seq%0d if_inst", got), if_inst, exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(posedge clk);
            if (inst_data_ok) outst = 1'b0;
            if (acc) begin
                outst = 1'b1;
                out_addr = held_addr;
            end
        end
        chk("seq deliveries", got, 24);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly upstream of the ID stage: it owns the PC, issues single-outstanding requests to the instruction SRAM, and loads the IF/ID register read by the ID decode and branch/forward logic. It consumes the ID-stage branch resolution (`jmp`, `dest`) with MIPS one-instruction delay-slot semantics, holds under the ID load-use stall, and redirects on exception/eret flush. A one-entry skid buffer absorbs SRAM data that returns while ID is stalled.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  ID cannot accept; IF/ID register, skid buffer and PC hold
- `jmp`  in  1  ID branch/jump taken; honoured only when `stall`=0 and `if_valid`=1
- `dest`  in  32  branch/jump target, valid with `jmp`
- `flush`  in  1  exception/eret redirect; highest priority
- `flush_pc`  in  32  redirect target
- `inst_req`  out  1  SRAM request valid
- `inst_addr`  out  32  SRAM request address (= PC)
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  read data valid this cycle
- `inst_rdata`  in  32  instruction word
- `if_valid`  out  1  IF/ID register holds an instruction
- `if_pc`  out  32  PC of that instruction
- `if_inst`  out  32  instruction word (0 when `if_adel`)
- `if_in_ds`  out  1  instruction is a branch delay slot (CP0 BD)
- `if_adel`  out  1  fetch address misaligned (PC[1:0]≠0)

## Operation
- State machine: REQ, WAIT, HOLD, ERR.
- REQ: `inst_req`=1, `inst_addr`=PC. `inst_addr_ok` → WAIT. If PC[1:0]≠0: no request; deliver {pc, inst=0, adel=1} as a normal delivery, then → ERR.
- WAIT: `inst_req`=0. On `inst_data_ok`: if `cancel`=1, drop data, clear `cancel`, → REQ. Else if IF/ID free (`if_valid`=0 or `stall`=0), deliver into IF/ID, → REQ. Else capture into skid buffer, → HOLD.
- HOLD: no request. When `stall`=0, deliver skid entry into IF/ID, → REQ.
- ERR: no request; leaves only via `flush` or `reset`.
- Delivery (into IF/ID) updates PC: next = (`jmp` honoured this cycle) ? `dest` : `pend_v` ? `pend_tgt` : delivered PC+4. `if_in_ds` = 1 on either of the first two cases; `pend_v` cleared.
- `jmp` honoured without a same-cycle delivery: `pend_v`←1, `pend_tgt`←`dest`. Only one pending target exists; the delay slot is always the next delivery, as PC advances only on delivery.
- `stall`=0 with no delivery: `if_valid`←0 (bubble). `stall`=1: IF/ID holds.
- `flush`: `if_valid`←0, skid cleared, `pend_v`←0, PC←`flush_pc`. From WAIT, or from REQ with `inst_addr_ok` same cycle: `cancel`←1, state WAIT; else → REQ. From HOLD/ERR → REQ. `flush` with `inst_data_ok` in WAIT: data dropped, → REQ, no cancel.
- PC arithmetic: 32-bit, modulo 2^32 (PC+4 from 32'hFFFF_FFFC wraps to 0).

## Timing
- Reset values: PC=`RESET_PC`, state REQ, `if_valid`=0, `if_pc`=0, `if_inst`=0, `if_in_ds`=0, `if_adel`=0, `pend_v`=0, `cancel`=0. `inst_req`=0 while `reset`=1, and 0 in the reset cycle.
- `inst_req` and `inst_addr` decode combinationally from state and PC; all other outputs are registered.
- Minimum fetch latency: REQ (addr_ok) → WAIT (data_ok) → IF/ID valid the following cycle. Back-to-back with zero-wait SRAM: one instruction per 2 cycles.
- `inst_addr` is stable while `inst_req`=1 and `inst_addr_ok`=0.
- Reset mid-transaction discards all state; a late `inst_data_ok` after reset is ignored unless in WAIT. The SRAM is reset with the core.

## Test plan
- Reset, zero-wait SRAM returning addr as data → `inst_addr` 0xBFC00000, 0xBFC00004, 0xBFC00008; `if_pc` matches; `if_valid` first high 2 cycles after reset release.
- Branch at 0xBFC00010: `jmp`=1, `dest`=0xBFC00100 while ID holds it → next delivered `if_pc`=0xBFC00014 with `if_in_ds`=1, then 0xBFC00100 with `if_in_ds`=0.
- `stall`=1 for 3 cycles while `inst_data_ok` returns → HOLD, no `inst_req`, `if_pc` frozen; stall release → skid entry appears next cycle with no loss or duplication.
- `flush`=1, `flush_pc`=0xBFC00380 in WAIT; stale `inst_data_ok` 2 cycles later → dropped; next delivered `if_pc`=0xBFC00380, `if_valid` low in between.
- `flush_pc`=0x00000102 → no `inst_req`; delivery with `if_adel`=1, `if_inst`=0, `if_pc`=0x00000102; stays in ERR until `flush` to 0xBFC00380.
- Delay slot delivered the same cycle `jmp` is honoured (data_ok coincident) → `if_in_ds`=1 and next `inst_addr`=`dest`; no pending target left.
